// File: rtl/dual_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : dual_issue_scoreboard
// Brief    : In-order dual-issue register scoreboard. Tracks pending register
//            writes, decides per-cycle issue of an older/younger instruction
//            pair, and counts stall cycles with saturation.
// Revision : 1.0 - initial release
// ============================================================================
module dual_issue_scoreboard #(
  // Architectural registers tracked (2..32); register 0 is the $zero register.
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  // Slot 0 (older) and slot 1 (younger) decoded instructions
  input  logic            in_valid0,
  input  logic            in_valid1,
  input  logic [4:0]      rs0,
  input  logic [4:0]      rt0,
  input  logic [4:0]      rd0,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rt1,
  input  logic [4:0]      rd1,
  input  logic            use_rs0,
  input  logic            use_rt0,
  input  logic            use_rs1,
  input  logic            use_rt1,
  input  logic            we0,
  input  logic            we1,
  // Register-file writeback ports
  input  logic            regwrite,
  input  logic            regwrite1,
  input  logic [4:0]      wrreg,
  input  logic [4:0]      wrreg1,
  // Issue decision and status
  output logic            issue0,
  output logic            issue1,
  output logic            stall,
  output logic [NREG-1:0] busy,
  output logic [15:0]     stall_cnt
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [15:0]     stall_cnt_q;
  logic [15:0]     stall_cnt_d;

  // Busy vector widened to the full 5-bit register space so every register
  // number can index it directly; bit 0 and untracked registers read as idle.
  logic [31:0]     busy_ext;

  for (genvar gi = 0; gi < 32; gi++) begin : g_busy_ext
    if (gi > 0 && gi < NREG) begin : g_live
      assign busy_ext[gi] = busy_q[gi];
    end else begin : g_dead
      assign busy_ext[gi] = 1'b0;
    end
  end

  // Per-source readiness. Each slot may only use write-through from its own
  // writeback port; a same-cycle write on the other port does not count.
  logic rs0_rdy, rt0_rdy, rs1_rdy, rt1_rdy;
  logic rd0_free, rd1_free;
  logic raw_hz, waw_hz;
  logic slot0_ok, slot1_ok;

  // Source readiness, destination availability and intra-pair hazards
  always_comb begin
    rs0_rdy  = !use_rs0 || !busy_ext[rs0] || (regwrite  && (wrreg  == rs0));
    rt0_rdy  = !use_rt0 || !busy_ext[rt0] || (regwrite  && (wrreg  == rt0));
    rs1_rdy  = !use_rs1 || !busy_ext[rs1] || (regwrite1 && (wrreg1 == rs1));
    rt1_rdy  = !use_rt1 || !busy_ext[rt1] || (regwrite1 && (wrreg1 == rt1));
    rd0_free = !we0 || (rd0 == 5'd0) || !busy_ext[rd0];
    rd1_free = !we1 || (rd1 == 5'd0) || !busy_ext[rd1];
    // Younger slot reads a register the older slot is about to write
    raw_hz   = we0 && (rd0 != 5'd0) &&
               ((use_rs1 && (rs1 == rd0)) || (use_rt1 && (rt1 == rd0)));
    // Both slots write the same non-zero register
    waw_hz   = we0 && we1 && (rd0 != 5'd0) && (rd0 == rd1);
    slot0_ok = rs0_rdy && rt0_rdy && rd0_free;
    slot1_ok = rs1_rdy && rt1_rdy && rd1_free && !raw_hz && !waw_hz;
  end

  // Issue decision: slot 1 only ever issues alongside slot 0 to keep order
  always_comb begin
    issue0 = in_valid0 && reset_n && slot0_ok;
    issue1 = issue0 && in_valid1 && slot1_ok;
    stall  = reset_n && in_valid0 && !issue0;
  end

  // Next busy state: clears from writeback, then sets from issue so that a
  // same-edge set overrides a clear on the same register
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREG; r++) begin
      if ((regwrite && (wrreg == 5'(r))) || (regwrite1 && (wrreg1 == 5'(r)))) begin
        busy_d[r] = 1'b0;
      end
      if ((issue0 && we0 && (rd0 == 5'(r))) || (issue1 && we1 && (rd1 == 5'(r)))) begin
        busy_d[r] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Next stall count, holding at the maximum value
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State registers; reset discards any writes still in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q      <= '0;
      stall_cnt_q <= 16'd0;
    end else begin
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy      = busy_q;
  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: doc/dual_issue_scoreboard.md
DUAL_ISSUE_SCOREBOARD -- requirements
Module: dual_issue_scoreboard

Interface
REQ-001 The block SHALL have parameter NREG, default 32: number of architectural registers tracked; register 0 is $zero.
REQ-002 The block SHALL have port clk  input  1: single clock, all state updates on the rising edge.
REQ-003 The block SHALL have port reset_n  input  1: synchronous, active-low reset.
REQ-004 The block SHALL have ports in_valid0, in_valid1  input  1 each: decoded instruction present in slot 0 (older) and slot 1 (younger).
REQ-005 The block SHALL have ports rs0, rt0, rd0, rs1, rt1, rd1  input  5 each: source and destination register numbers per slot.
REQ-006 The block SHALL have ports use_rs0, use_rt0, use_rs1, use_rt1  input  1 each: the source operand is actually read.
REQ-007 The block SHALL have ports we0, we1  input  1 each: the slot writes rd.
REQ-008 The block SHALL have ports regwrite, regwrite1  input  1 each: writeback strobes to register-file ports 0 and 1.
REQ-009 The block SHALL have ports wrreg, wrreg1  input  5 each: writeback destinations on ports 0 and 1.
REQ-010 The block SHALL have ports issue0, issue1  output  1 each: the slot issues this cycle.
REQ-011 The block SHALL have port stall  output  1: in_valid0 high and issue0 low.
REQ-012 The block SHALL have port busy  output  NREG: registered pending-write vector.
REQ-013 The block SHALL have port stall_cnt  output  16: saturating count of stall cycles.

Function
REQ-014 busy[r] SHALL be set at the clock edge on which a slot issues with we=1 and rd=r, r!=0.
REQ-015 busy[r] SHALL be cleared at the clock edge on which regwrite=1 with wrreg=r, or regwrite1=1 with wrreg1=r.
REQ-016 When a set and a clear hit the same register on the same edge, the set SHALL win.
REQ-017 busy[0] SHALL be constant 0; rd=0 SHALL never set busy; a source of 0 SHALL never be treated as busy.
REQ-018 A slot-0 source r SHALL be ready if busy[r]=0, or if regwrite=1 and wrreg=r in the same cycle (port-0 write-through only).
REQ-019 A slot-1 source r SHALL be ready if busy[r]=0, or if regwrite1=1 and wrreg1=r in the same cycle (port-1 write-through only); a same-cycle write on the other port SHALL NOT make it ready.
REQ-020 Sources with use_*=0 SHALL always be ready.
REQ-021 issue0 SHALL equal in_valid0 AND reset_n AND both slot-0 sources ready AND (we0=0 OR rd0=0 OR busy[rd0]=0).
REQ-022 issue1 SHALL equal issue0 AND in_valid1 AND both slot-1 sources ready AND (we1=0 OR rd1=0 OR busy[rd1]=0) AND no intra-pair hazard.
REQ-023 An intra-pair RAW hazard SHALL be we0=1, rd0!=0, and a used slot-1 source equal to rd0.
REQ-024 An intra-pair WAW hazard SHALL be we0=1, we1=1, and rd0=rd1!=0.
REQ-025 Slot 1 SHALL never issue without slot 0; the pair SHALL stay in order.
REQ-026 issue0, issue1 and stall SHALL be combinational from inputs and registered state, with zero-cycle latency.
REQ-027 stall_cnt SHALL increment on every edge where stall=1.
REQ-028 stall_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-029 While reset_n=0 at a rising edge, busy SHALL become all zeros and stall_cnt SHALL become 0.
REQ-030 While reset_n=0, issue0, issue1 and stall SHALL be 0 and no busy bit SHALL be set.
REQ-031 Reset SHALL take priority over any issue or writeback in the same cycle, so pending writes in flight at reset are forgotten.

Verification
REQ-032 Independent pair: slot0 rd0=8, we0=1, rs0=9; slot1 rd1=10, rs1=11 -> issue0=issue1=1; next cycle busy[8]=busy[10]=1.
REQ-033 Intra-pair RAW: slot0 writes $8, slot1 uses rs1=8 -> issue0=1, issue1=0; busy[8] set; stall=0.
REQ-034 Cross-port write-through: busy[9]=1, slot1 needs $9, regwrite=1 wrreg=9 -> issue1=0. Repeating with regwrite1=1 wrreg1=9 -> issue1=1.
REQ-035 Set/clear collision: busy[12]=1, regwrite1 clears $12 while slot0 issues we0=1 rd0=12 -> busy[12]=1 after the edge.
REQ-036 Zero register and saturation: rd0=0, we0=1 -> busy stays 0. Preloading stall_cnt to 16'hFFFE and stalling 3 cycles -> stall_cnt=16'hFFFF.
REQ-037 Reset mid-operation: busy=32'h0000_0F00, stall_cnt=5, reset_n=0 one edge -> busy=0, stall_cnt=0, and issue0=0 during reset.
